// File: rtl/aes_bram_read_responder.sv
// Word-read responder for the AES controller: one fixed-latency BRAM read per request, bad addresses answered with 0.
// Latency: complete in cycle READ_LATENCY+2 (valid) or cycle 1 (error); re-arms only after the request line is seen low.
module aes_bram_read_responder #(
  parameter int          ADDR_W       = 10,
  parameter int          DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 2
) (
  input  logic              aes_clk,
  input  logic              aes_rst,
  input  logic              aes_start_read,
  input  logic [31:0]       aes_bram_addr,
  output logic              bram_complete,
  output logic [31:0]       aes_bram_read_data,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [31:0]       bram_dout,
  output logic              bram_error,
  output logic [31:0]       bram_err_addr,
  output logic [31:0]       bram_req_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, REARM} state_t;

  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
  localparam logic [3:0]  RL_L    = 4'(READ_LATENCY);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              complete_q, complete_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic              err_q, err_d;
  logic [31:0]       err_addr_q, err_addr_d;
  logic [31:0]       bram_req_count_q, bram_req_count_d;

  logic [31:0] offset;
  logic        req_valid;

  // Validity is judged on the word being captured so the error response can fire in cycle 1.
  always_comb begin
    offset    = aes_bram_addr - BASE_ADDR;
    req_valid = (aes_bram_addr[1:0] == 2'b00) &&
                (aes_bram_addr >= BASE_ADDR) &&
                ({2'b00, offset[31:2]} < DEPTH_L);
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    complete_d       = 1'b0;
    rdata_d          = rdata_q;
    en_d             = 1'b0;
    baddr_d          = baddr_q;
    err_d            = err_q;
    err_addr_d       = err_addr_q;
    bram_req_count_d = bram_req_count_q;
    case (state_q)
      IDLE: begin
        if (aes_start_read) begin
          if (req_valid) begin
            state_d = ISSUE;
            en_d    = 1'b1;
            baddr_d = offset[ADDR_W+1:2];
          end else begin
            state_d          = RESP;
            rdata_d          = 32'h0;
            complete_d       = 1'b1;
            bram_req_count_d = bram_req_count_q + 32'd1;
            if (!err_q) begin
              err_d      = 1'b1;
              err_addr_d = aes_bram_addr;
            end
          end
        end
      end
      ISSUE: begin
        cnt_d   = RL_L;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          rdata_d          = bram_dout;
          complete_d       = 1'b1;
          bram_req_count_d = bram_req_count_q + 32'd1;
          state_d          = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = REARM;
      REARM: begin
        if (!aes_start_read) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aes_clk) begin
    if (aes_rst) begin
      state_q          <= IDLE;
      cnt_q            <= 4'd0;
      complete_q       <= 1'b0;
      rdata_q          <= 32'h0;
      en_q             <= 1'b0;
      baddr_q          <= '0;
      err_q            <= 1'b0;
      err_addr_q       <= 32'h0;
      bram_req_count_q <= 32'h0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      complete_q       <= complete_d;
      rdata_q          <= rdata_d;
      en_q             <= en_d;
      baddr_q          <= baddr_d;
      err_q            <= err_d;
      err_addr_q       <= err_addr_d;
      bram_req_count_q <= bram_req_count_d;
    end
  end

  assign bram_complete      = complete_q;
  assign aes_bram_read_data = rdata_q;
  assign bram_en            = en_q;
  assign bram_addr          = baddr_q;
  assign bram_error         = err_q;
  assign bram_err_addr      = err_addr_q;
  assign bram_req_count     = bram_req_count_q;

endmodule

// File: tb/tb_aes_bram_read_responder.sv
// Bench: four responders (latency 2/1/15, and a 0x4000_0000 window) share one request stream, each with its own BRAM model.
module tb_aes_bram_read_responder;

  localparam int NI = 4;

  function automatic int rl_of(input int g);
    case (g)
      0: return 2;
      1: return 1;
      2: return 15;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int g);
    return (g == 3) ? 32'h4000_0000 : 32'h0000_0000;
  endfunction

  function automatic logic [31:0] mem_word(input int g, input logic [9:0] w);
    return {8'hA5 ^ 8'(g), 8'hA5, 6'd0, w};
  endfunction

  logic        clk, rst, start;
  logic [31:0] addr;
  logic [NI-1:0] cmp_w, en_w, err_w;
  logic [31:0] data_w [NI];
  logic [31:0] dout_w [NI];
  logic [31:0] err_addr_w [NI];
  logic [31:0] cnt_w [NI];
  logic [9:0]  adr_w [NI];

  int n_tests = 0;
  int n_fail  = 0;

  logic        exp_err [NI];
  logic [31:0] exp_err_addr [NI];
  logic [31:0] exp_cnt [NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int RL = rl_of(g);
    logic [31:0] pipe [RL];
    always_ff @(posedge clk) begin
      pipe[0] <= en_w[g] ? mem_word(g, adr_w[g]) : 32'hDEAD_BEEF;
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign dout_w[g] = pipe[RL-1];

    aes_bram_read_responder #(
      .ADDR_W(10), .DEPTH_WORDS(1024), .BASE_ADDR(base_of(g)), .READ_LATENCY(RL)
    ) u_dut (
      .aes_clk(clk), .aes_rst(rst), .aes_start_read(start), .aes_bram_addr(addr),
      .bram_complete(cmp_w[g]), .aes_bram_read_data(data_w[g]),
      .bram_en(en_w[g]), .bram_addr(adr_w[g]), .bram_dout(dout_w[g]),
      .bram_error(err_w[g]), .bram_err_addr(err_addr_w[g]), .bram_req_count(cnt_w[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < NI; g++) begin
      check_eq($sformatf("%s i%0d complete", tag, g), 32'(cmp_w[g]), 32'd0);
      check_eq($sformatf("%s i%0d rdata", tag, g), data_w[g], 32'd0);
      check_eq($sformatf("%s i%0d en", tag, g), 32'(en_w[g]), 32'd0);
      check_eq($sformatf("%s i%0d baddr", tag, g), 32'(adr_w[g]), 32'd0);
      check_eq($sformatf("%s i%0d err", tag, g), 32'(err_w[g]), 32'd0);
      check_eq($sformatf("%s i%0d err_addr", tag, g), err_addr_w[g], 32'd0);
      check_eq($sformatf("%s i%0d count", tag, g), cnt_w[g], 32'd0);
    end
  endtask

  // One request, held until the negedge of cycle drop_cyc; every instance is watched for 24 cycles.
  task automatic do_req(input logic [31:0] a, input int drop_cyc);
    int          c_cyc [NI];
    int          n_cmp [NI];
    int          n_en  [NI];
    int          en_cyc [NI];
    logic [31:0] c_dat [NI];
    logic [9:0]  en_adr [NI];
    logic [31:0] off, exp_dat;
    logic        v;
    for (int g = 0; g < NI; g++) begin
      c_cyc[g] = 0; n_cmp[g] = 0; n_en[g] = 0; en_cyc[g] = 0;
      c_dat[g] = 32'h0; en_adr[g] = 10'h0;
    end
    @(negedge clk);
    start = 1'b1;
    addr  = a;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      if (cyc == 1) addr = $urandom;
      for (int g = 0; g < NI; g++) begin
        if (cmp_w[g]) begin n_cmp[g]++; c_cyc[g] = cyc; c_dat[g] = data_w[g]; end
        if (en_w[g])  begin n_en[g]++;  en_cyc[g] = cyc; en_adr[g] = adr_w[g]; end
      end
      if (cyc == drop_cyc) start = 1'b0;
    end
    for (int g = 0; g < NI; g++) begin
      off     = a - base_of(g);
      v       = (a[1:0] == 2'b00) && (a >= base_of(g)) && ((off >> 2) < 32'd1024);
      exp_dat = v ? mem_word(g, off[11:2]) : 32'h0;
      exp_cnt[g] = exp_cnt[g] + 32'd1;
      if (!v && !exp_err[g]) begin
        exp_err[g]      = 1'b1;
        exp_err_addr[g] = a;
      end
      check_eq($sformatf("a=%0h i%0d n_complete", a, g), 32'(n_cmp[g]), 32'd1);
      check_eq($sformatf("a=%0h i%0d complete_cycle", a, g), 32'(c_cyc[g]),
               v ? 32'(rl_of(g) + 2) : 32'd1);
      check_eq($sformatf("a=%0h i%0d data", a, g), c_dat[g], exp_dat);
      check_eq($sformatf("a=%0h i%0d data_held", a, g), data_w[g], exp_dat);
      check_eq($sformatf("a=%0h i%0d n_en", a, g), 32'(n_en[g]), 32'(v));
      if (v) begin
        check_eq($sformatf("a=%0h i%0d en_cycle", a, g), 32'(en_cyc[g]), 32'd1);
        check_eq($sformatf("a=%0h i%0d en_addr", a, g), 32'(en_adr[g]), 32'(off[11:2]));
      end
      check_eq($sformatf("a=%0h i%0d err", a, g), 32'(err_w[g]), 32'(exp_err[g]));
      check_eq($sformatf("a=%0h i%0d err_addr", a, g), err_addr_w[g], exp_err_addr[g]);
      check_eq($sformatf("a=%0h i%0d count", a, g), cnt_w[g], exp_cnt[g]);
    end
  endtask

  task automatic reset_mid_wait();
    int n_cmp;
    @(negedge clk);
    start = 1'b1;
    addr  = 32'h20;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    rst   = 1'b0;
    start = 1'b0;
    for (int g = 0; g < NI; g++) begin
      exp_err[g] = 1'b0; exp_err_addr[g] = 32'h0; exp_cnt[g] = 32'h0;
    end
    n_cmp = 0;
    repeat (20) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) if (cmp_w[g] || en_w[g]) n_cmp++;
    end
    check_eq("rst_mid no_activity", 32'(n_cmp), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          sel, drop;
    rst = 1'b1; start = 1'b0; addr = 32'h0;
    for (int g = 0; g < NI; g++) begin
      exp_err[g] = 1'b0; exp_err_addr[g] = 32'h0; exp_cnt[g] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    do_req(32'h14, 20);
    for (int i = 0; i < 12; i++) do_req(32'(i * 4), 18);
    do_req(32'h0000_0006, 20);
    do_req(32'h0000_1000, 20);
    do_req(32'h3FFF_FFFC, 20);
    do_req(32'h4000_0FFC, 20);

    for (int k = 0; k < 16; k++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: a = 32'($urandom_range(0, 1023)) << 2;
        1: a = 32'h4000_0000 + (32'($urandom_range(0, 1023)) << 2);
        2: a = (32'($urandom_range(0, 2047)) << 2) | 32'($urandom_range(1, 3));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: drop = 2;
        1: drop = 5;
        2: drop = 18;
        default: drop = 20;
      endcase
      do_req(a, drop);
    end

    reset_mid_wait();
    do_req(32'h20, 20);
    do_req(32'h4000_0020, 3);

    @(negedge clk);
    force g_dut[0].u_dut.bram_req_count_q = 32'hFFFF_FFFF;
    #2;
    release g_dut[0].u_dut.bram_req_count_q;
    exp_cnt[0] = 32'hFFFF_FFFF;
    do_req(32'h14, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
